dmemory_be: RTL and testbench

- Parametrised successor to the 32-bit word-only data RAM.
- Single-clock synchronous data memory with byte, halfword and word stores and loads, signed and unsigned load extension, and misalignment detection.
- Includes an integrated program/run mode FSM, so the UART programmer can load memory through this block instead of external muxing.
- Sits between ALU/decoder/controller and the register-file writeback path.

---
 rtl/dmemory_be.sv | 177 +++++++++++++++++
 tb/tb_dmemory_be.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dmemory_be.sv
// Byte-lane data memory with sized/signed loads, misalignment rejection and an
// integrated programmer (PROG) / CPU (RUN) mode controller.
module dmemory_be #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 14,
  parameter int PROG_ON_RESET = 1
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [31:0]       address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic              misalign,
  input  logic              upg_wen_i,
  input  logic [ADDR_W-1:0] upg_adr_i,
  input  logic [DATA_W-1:0] upg_dat_i,
  input  logic              upg_done_i,
  input  logic              upg_start_i,
  output logic              prog_mode,
  output logic [ADDR_W:0]   upg_count
);

  localparam int LANES = DATA_W / 8;
  localparam int LB    = $clog2(LANES);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic {ST_PROG, ST_RUN} state_t;

  state_t state_reg, state_next;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state_reg <= (PROG_ON_RESET != 0) ? ST_PROG : ST_RUN;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_PROG: if (upg_done_i)  state_next = ST_RUN;
      ST_RUN:  if (upg_start_i) state_next = ST_PROG;
      default: state_next = state_reg;
    endcase
  end

  logic run_mode;
  assign run_mode  = (state_reg == ST_RUN);
  assign prog_mode = ~run_mode;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)
      upg_count <= '0;
    else if (run_mode && state_next == ST_PROG)
      upg_count <= '0;
    else if (!run_mode && upg_wen_i && upg_count != COUNT_MAX)
      upg_count <= upg_count + 1'b1;
  end

  // CPU access decode; higher address bits are dropped so accesses wrap.
  logic [LB-1:0]     offset;
  logic [ADDR_W-1:0] cpu_idx;
  logic              size_ok, store_en, load_en, reject;

  assign offset  = address[LB-1:0];
  assign cpu_idx = address[ADDR_W+LB-1:LB];

  always_comb begin
    size_ok = 1'b0;
    case (mem_size)
      2'b00:   size_ok = (int'(offset) < LANES);
      2'b01:   size_ok = !offset[0] && (int'(offset) + 1 < LANES);
      2'b10:   size_ok = (offset == '0);
      default: size_ok = 1'b0;
    endcase
  end

  assign store_en = run_mode && mem_write && size_ok;
  assign load_en  = run_mode && mem_read && !mem_write && size_ok;
  assign reject   = run_mode && (mem_read || mem_write) && !size_ok;

  logic unused_addr;
  assign unused_addr = &{1'b0, address[31:ADDR_W+LB]};

  logic [DATA_W-1:0] rd_word;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0]        ram [DEPTH];
      logic [7:0]        rd_reg;
      logic              we;
      logic [7:0]        wdat;
      logic [ADDR_W-1:0] widx;
      logic              hit_lo, hit_hi;

      assign hit_lo = (int'(offset) == gi);
      assign hit_hi = (int'(offset) + 1 == gi);

      always_comb begin
        we   = 1'b0;
        wdat = write_data[8*gi +: 8];
        widx = cpu_idx;
        if (!run_mode) begin
          we   = upg_wen_i;
          wdat = upg_dat_i[8*gi +: 8];
          widx = upg_adr_i;
        end else if (store_en) begin
          case (mem_size)
            2'b00: begin
              we   = hit_lo;
              wdat = write_data[7:0];
            end
            2'b01: begin
              we   = hit_lo | hit_hi;
              wdat = hit_lo ? write_data[7:0] : write_data[15:8];
            end
            default: we = 1'b1;
          endcase
        end
      end

      always_ff @(posedge clock) begin
        if (we)      ram[widx] <= wdat;
        if (load_en) rd_reg    <= ram[cpu_idx];
      end

      assign rd_word[8*gi +: 8] = rd_reg;
    end
  endgenerate

  // Load attributes travel alongside the RAM read so formatting happens on output.
  logic [1:0]    size_reg;
  logic [LB-1:0] off_reg;
  logic          uns_reg;
  logic          have_reg;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      read_valid <= 1'b0;
      misalign   <= 1'b0;
      size_reg   <= '0;
      off_reg    <= '0;
      uns_reg    <= 1'b0;
      have_reg   <= 1'b0;
    end else begin
      read_valid <= load_en;
      misalign   <= reject;
      if (load_en) begin
        size_reg <= mem_size;
        off_reg  <= offset;
        uns_reg  <= mem_unsigned;
        have_reg <= 1'b1;
      end
    end
  end

  logic [DATA_W-1:0] shifted, fmt;

  assign shifted = rd_word >> {off_reg, 3'b000};

  always_comb begin
    fmt = shifted;
    case (size_reg)
      2'b00:   fmt = {{(DATA_W-8){~uns_reg & shifted[7]}}, shifted[7:0]};
      2'b01:   fmt = {{(DATA_W-16){~uns_reg & shifted[15]}}, shifted[15:0]};
      default: fmt = shifted;
    endcase
  end

  assign read_data = have_reg ? fmt : '0;

endmodule

// File: tb/tb_dmemory_be.sv
// Directed plus randomized check of dmemory_be against a byte-array reference model.
module tb_dmemory_be;

  localparam int ADDR_W = 14;

  logic              clock = 1'b0;
  logic              rst_n = 1'b0;
  logic              mem_read = 1'b0, mem_write = 1'b0, mem_unsigned = 1'b0;
  logic [1:0]        mem_size = 2'b00;
  logic [31:0]       address = '0, write_data = '0;
  logic [31:0]       read_data;
  logic              read_valid, misalign;
  logic              upg_wen_i = 1'b0, upg_done_i = 1'b0, upg_start_i = 1'b0;
  logic [ADDR_W-1:0] upg_adr_i = '0;
  logic [31:0]       upg_dat_i = '0;
  logic              prog_mode;
  logic [ADDR_W:0]   upg_count;

  dmemory_be #(.DATA_W(32), .ADDR_W(ADDR_W), .PROG_ON_RESET(1)) dut (
    .clock(clock), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .address(address), .write_data(write_data),
    .read_data(read_data), .read_valid(read_valid), .misalign(misalign),
    .upg_wen_i(upg_wen_i), .upg_adr_i(upg_adr_i), .upg_dat_i(upg_dat_i),
    .upg_done_i(upg_done_i), .upg_start_i(upg_start_i),
    .prog_mode(prog_mode), .upg_count(upg_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: 16 words of byte storage, plus the last returned load value.
  logic [7:0]  mb [0:63];
  logic [31:0] last_rd = '0;
  bit          model_run = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] mload(input int base, input int off, input logic [1:0] sz, input bit u);
    logic [7:0]  b;
    logic [15:0] h;
    if (sz == 2'd0) begin
      b = mb[base+off];
      return u ? {24'h0, b} : {{24{b[7]}}, b};
    end else if (sz == 2'd1) begin
      h = {mb[base+off+1], mb[base+off]};
      return u ? {16'h0, h} : {{16{h[15]}}, h};
    end
    return {mb[base+3], mb[base+2], mb[base+1], mb[base]};
  endfunction

  task automatic mstore(input int base, input int off, input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd0) mb[base+off] = wd[7:0];
    else if (sz == 2'd1) begin
      mb[base+off]   = wd[7:0];
      mb[base+off+1] = wd[15:8];
    end else
      for (int k = 0; k < 4; k++) mb[base+k] = wd[8*k +: 8];
  endtask

  task automatic cpu_op(input bit rd, input bit wr, input logic [1:0] sz, input bit u,
                        input logic [31:0] a, input logic [31:0] wd, input string tag);
    int off, base;
    bit legal, ev, em;
    logic [31:0] ed;
    off   = int'(a % 4);
    base  = int'(((a & 32'hFFFF) / 4) * 4);
    legal = (sz == 2'd0) || (sz == 2'd1 && off % 2 == 0) || (sz == 2'd2 && off == 0);
    ev    = model_run && rd && !wr && legal;
    em    = model_run && (rd || wr) && !legal;
    ed    = ev ? mload(base, off, sz, u) : last_rd;
    mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = u;
    address = a; write_data = wd;
    tick();
    mem_read = 1'b0; mem_write = 1'b0;
    chk({tag, " read_valid"}, {31'b0, read_valid}, {31'b0, ev});
    chk({tag, " misalign"}, {31'b0, misalign}, {31'b0, em});
    chk({tag, " read_data"}, read_data, ed);
    last_rd = ed;
    if (model_run && wr && legal) mstore(base, off, sz, wd);
    $display("op %-10s rd=%0d wr=%0d size=%0d uns=%0d addr=%08h wd=%08h -> valid=%0d mis=%0d data=%08h",
             tag, rd, wr, sz, u, a, wd, read_valid, misalign, read_data);
  endtask

  task automatic upg_write(input int w, input logic [31:0] d, input bit done);
    upg_wen_i = 1'b1; upg_adr_i = ADDR_W'(w); upg_dat_i = d; upg_done_i = done;
    tick();
    upg_wen_i = 1'b0; upg_done_i = 1'b0;
    if (w < 16) for (int k = 0; k < 4; k++) mb[4*w+k] = d[8*k +: 8];
    $display("upg word=%0d data=%08h done=%0d -> count=%0d prog=%0d", w, d, done, upg_count, prog_mode);
  endtask

  initial begin
    logic [31:0] init_words [0:3];
    init_words[0] = 32'h11223344; init_words[1] = 32'h8899AABB;
    init_words[2] = 32'h0;        init_words[3] = 32'h0;

    // Reset
    repeat (2) @(posedge clock);
    #1 rst_n = 1'b1;
    chk("rst prog_mode", {31'b0, prog_mode}, 32'd1);
    chk("rst read_data", read_data, 32'h0);
    chk("rst read_valid", {31'b0, read_valid}, 32'd0);
    chk("rst misalign", {31'b0, misalign}, 32'd0);
    chk("rst upg_count", 32'(upg_count), 32'd0);

    // Programming, last write coincides with done
    for (int w = 0; w < 4; w++) upg_write(w, init_words[w], w == 3);
    chk("prog count", 32'(upg_count), 32'd4);
    chk("prog exit", {31'b0, prog_mode}, 32'd0);
    model_run = 1'b1;

    // Directed loads and stores
    cpu_op(1, 0, 2'd2, 0, 32'h4, 0, "ldw4");
    chk("ldw4 literal", read_data, 32'h8899AABB);
    cpu_op(1, 0, 2'd0, 0, 32'h5, 0, "ldbs5");
    chk("ldbs5 literal", read_data, 32'hFFFFFFAA);
    cpu_op(1, 0, 2'd0, 1, 32'h5, 0, "ldbu5");
    chk("ldbu5 literal", read_data, 32'h000000AA);
    cpu_op(0, 1, 2'd0, 0, 32'h2, 32'h000000EE, "stb2");
    cpu_op(1, 0, 2'd2, 0, 32'h0, 0, "ldw0");
    chk("ldw0 literal", read_data, 32'h11EE3344);
    cpu_op(0, 1, 2'd1, 0, 32'h0, 32'h0000BEEF, "sth0");
    cpu_op(1, 0, 2'd1, 0, 32'h0, 0, "ldhs0");
    chk("ldhs0 literal", read_data, 32'hFFFFBEEF);

    // Rejected accesses
    cpu_op(1, 0, 2'd1, 0, 32'h1, 0, "ldh1bad");
    cpu_op(0, 0, 2'd0, 0, 32'h0, 0, "idle");
    cpu_op(0, 1, 2'd2, 0, 32'h6, 32'hDEADBEEF, "stw6bad");
    cpu_op(1, 0, 2'd3, 0, 32'h0, 0, "size3bad");
    cpu_op(1, 0, 2'd2, 0, 32'h0, 0, "ldw0b");
    chk("ldw0b literal", read_data, 32'h11EEBEEF);

    // Aliasing and read+write together
    cpu_op(1, 0, 2'd2, 0, 32'h00010004, 0, "alias");
    chk("alias literal", read_data, 32'h8899AABB);
    cpu_op(1, 1, 2'd2, 0, 32'h8, 32'hCAFEF00D, "rdwr8");
    cpu_op(1, 0, 2'd2, 0, 32'h8, 0, "ldw8");
    chk("ldw8 literal", read_data, 32'hCAFEF00D);

    // Fill the rest of the model window, then random traffic
    for (int w = 4; w < 16; w++) cpu_op(0, 1, 2'd2, 0, 32'(4*w), $urandom(), "fill");
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = ($urandom() & 32'hFFFF0000) | 32'($urandom_range(0, 63));
      cpu_op(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom(), "rand");
    end

    // Re-enter PROG with a CPU load in the same cycle
    upg_start_i = 1'b1;
    cpu_op(1, 0, 2'd2, 0, 32'h0, 0, "ldstart");
    upg_start_i = 1'b0;
    model_run = 1'b0;
    chk("start prog_mode", {31'b0, prog_mode}, 32'd1);
    chk("start count", 32'(upg_count), 32'd0);
    cpu_op(0, 1, 2'd2, 0, 32'h0, 32'h01020304, "stprog");
    cpu_op(1, 0, 2'd2, 0, 32'h0, 0, "ldprog");

    // Count saturation using a word outside the model window
    upg_wen_i = 1'b1; upg_adr_i = ADDR_W'(20);
    for (int i = 0; i < (1 << ADDR_W) + 3; i++) begin
      upg_dat_i = $urandom();
      tick();
    end
    upg_wen_i = 1'b0;
    chk("sat count", 32'(upg_count), 32'(1 << ADDR_W));
    $display("upg saturation -> count=%0d", upg_count);

    upg_done_i = 1'b1;
    tick();
    upg_done_i = 1'b0;
    model_run = 1'b1;
    chk("done2 prog_mode", {31'b0, prog_mode}, 32'd0);
    cpu_op(1, 0, 2'd2, 0, 32'h0, 0, "ldafter");

    // Asynchronous reset while a load result is being presented
    cpu_op(1, 0, 2'd0, 1, 32'h5, 0, "ldpre");
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst read_valid", {31'b0, read_valid}, 32'd0);
    chk("mid rst read_data", read_data, 32'h0);
    chk("mid rst misalign", {31'b0, misalign}, 32'd0);
    chk("mid rst prog_mode", {31'b0, prog_mode}, 32'd1);
    chk("mid rst count", 32'(upg_count), 32'd0);
    $display("reset mid-load -> valid=%0d data=%08h prog=%0d", read_valid, read_data, prog_mode);
    tick();
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
